// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: stall bus encoding,
// exception codes, default handler address and the drain FSM state type.
package pipe_ctrl_pkg;

  localparam int unsigned StallBusW = 6;
  localparam logic        Stop      = 1'b1;
  localparam logic        NoStop    = 1'b0;

  // Stall vector bit order: PC, IF, ID, EX, MEM, WB (bit0..bit5).
  localparam logic [StallBusW-1:0] StallNone = 6'b000000;
  localparam logic [StallBusW-1:0] StallIdIf = 6'b000111;
  localparam logic [StallBusW-1:0] StallEx   = 6'b001111;
  localparam logic [StallBusW-1:0] StallMem  = 6'b011111;

  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_INVALID = 32'h0000_000a;
  localparam logic [31:0] EXC_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

  localparam logic [31:0] HandlerAddrDefault = 32'h0000_0020;

  typedef enum logic {
    StIdle,
    StDrain
  } drain_state_e;

  // Highest-priority requester decides how far back the pipeline freezes.
  function automatic logic [StallBusW-1:0] stall_vec(input logic req_mem, input logic req_ex,
                                                     input logic req_id, input logic req_if);
    if (req_mem) begin
      return StallMem;
    end else if (req_ex) begin
      return StallEx;
    end else if (req_id || req_if) begin
      return StallIdIf;
    end
    return StallNone;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst (async active-low), inc (count enable), clr (sync clear,
// wins over inc), cnt (current count, sticks at all-ones).
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: merges stall requests into the 6-bit stall vector,
// turns accepted MEM exceptions into a one-cycle flush with redirect PC, marks
// the stale fetch to discard after a flush, and keeps perf counters.
// Ports: clk, rst (async active-low); stallreq_from_{if,id,ex,mem};
// excepttype_i, cp0_epc_i; cnt_clr; stall, flush, new_pc, if_discard;
// stall_cycles, flush_count.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = HandlerAddrDefault,
  parameter int unsigned STALL_CNT_W  = 32,
  parameter int unsigned FLUSH_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stallreq_from_if,
  input  logic                   stallreq_from_id,
  input  logic                   stallreq_from_ex,
  input  logic                   stallreq_from_mem,
  input  logic [31:0]            excepttype_i,
  input  logic [31:0]            cp0_epc_i,
  input  logic                   cnt_clr,
  output logic [5:0]             stall,
  output logic                   flush,
  output logic [31:0]            new_pc,
  output logic                   if_discard,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic [FLUSH_CNT_W-1:0] flush_count
);

  drain_state_e state_q, state_d;
  logic         accept;

  // A busy data bus holds the exception off; the MEM stall covers it meanwhile.
  assign accept = rst && (excepttype_i != '0) && !stallreq_from_mem;

  always_comb begin
    stall  = StallNone;
    flush  = NoStop;
    new_pc = '0;
    if (rst) begin
      if (accept) begin
        flush = Stop;
        unique case (excepttype_i)
          EXC_ERET: new_pc = cp0_epc_i;
          EXC_INT, EXC_SYSCALL, EXC_INVALID, EXC_OV, EXC_TRAP: new_pc = HANDLER_ADDR;
          default:  new_pc = HANDLER_ADDR;
        endcase
      end else begin
        stall = stall_vec(stallreq_from_mem, stallreq_from_ex, stallreq_from_id,
                          stallreq_from_if);
      end
    end
  end

  // DRAIN covers the fetch that was in flight at flush time, including the
  // cycle it finally returns (stallreq_from_if low).
  always_comb begin
    state_d    = state_q;
    if_discard = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (flush && stallreq_from_if) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if_discard = rst;
        if (!stallreq_from_if) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  sat_counter #(
    .W(STALL_CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall != StallNone),
    .clr (cnt_clr),
    .cnt (stall_cycles)
  );

  sat_counter #(
    .W(FLUSH_CNT_W)
  ) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush),
    .clr (cnt_clr),
    .cnt (flush_count)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_if, req_id, req_ex, req_mem;
  logic [31:0] exc, epc;
  logic        cnt_clr;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        if_discard;
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_if  (req_if),
    .stallreq_from_id  (req_id),
    .stallreq_from_ex  (req_ex),
    .stallreq_from_mem (req_mem),
    .excepttype_i      (exc),
    .cp0_epc_i         (epc),
    .cnt_clr           (cnt_clr),
    .stall             (stall),
    .flush             (flush),
    .new_pc            (new_pc),
    .if_discard        (if_discard),
    .stall_cycles      (stall_cycles),
    .flush_count       (flush_count)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: fetch-outstanding flag plus plain integer counters.
  bit          m_pending = 1'b0;
  longint      m_stalls  = 0;
  longint      m_flushes = 0;
  bit          e_flush;
  logic [5:0]  e_stall;
  logic [31:0] e_pc;

  function automatic void model_outputs();
    bit taken;
    taken   = (rst === 1'b1) && (exc != 0) && !req_mem;
    e_flush = taken;
    e_pc    = !taken ? 32'h0 : (exc == 32'he) ? epc : 32'h20;
    if (rst !== 1'b1 || taken) e_stall = 6'h00;
    else if (req_mem)          e_stall = 6'h1f;
    else if (req_ex)           e_stall = 6'h0f;
    else if (req_id || req_if) e_stall = 6'h07;
    else                       e_stall = 6'h00;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (rst !== 1'b1) begin
      m_pending = 1'b0;
      m_stalls  = 0;
      m_flushes = 0;
    end else begin
      model_outputs();
      m_pending = m_pending ? req_if : (e_flush && req_if);
      if (cnt_clr) begin
        m_stalls  = 0;
        m_flushes = 0;
      end else begin
        if (e_stall != 0 && m_stalls < 64'hffff_ffff) m_stalls++;
        if (e_flush && m_flushes < 64'hffff) m_flushes++;
      end
    end
  end

  always @(negedge clk) begin
    model_outputs();
    chk("stall", 64'(stall), 64'(e_stall));
    chk("flush", 64'(flush), 64'(e_flush));
    chk("new_pc", 64'(new_pc), 64'(e_pc));
    chk("if_discard", 64'(if_discard), 64'((rst === 1'b1) && m_pending));
    chk("stall_cycles", 64'(stall_cycles), m_stalls);
    chk("flush_count", 64'(flush_count), m_flushes);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; req_if = 1'b1; req_id = 1'b1; req_ex = 1'b1; req_mem = 1'b1;
    exc = 32'h8; epc = 32'h0; cnt_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_stall", 64'(stall), 64'h0);
    chk("rst_flush", 64'(flush), 64'h0);
    chk("rst_new_pc", 64'(new_pc), 64'h0);
    chk("rst_discard", 64'(if_discard), 64'h0);
    chk("rst_cnts", 64'(stall_cycles) + 64'(flush_count), 64'h0);
    next_cyc();
    req_if = 1'b0; req_id = 1'b0; req_ex = 1'b0; req_mem = 1'b0; exc = 32'h0;
    rst = 1'b1;

    // Stall priority and stall-cycle count.
    next_cyc(); req_id = 1'b1; req_ex = 1'b1;
    @(negedge clk); chk("lit_stall_id_ex", 64'(stall), 64'h0f);
    next_cyc(); req_ex = 1'b0;
    @(negedge clk); chk("lit_stall_id", 64'(stall), 64'h07);
    repeat (9) @(posedge clk);
    #1 req_id = 1'b0;
    @(negedge clk); chk("lit_stall_cycles_10", 64'(stall_cycles), 64'd10);

    // Syscall.
    next_cyc(); exc = 32'h8;
    @(negedge clk);
    chk("lit_sys_flush", 64'(flush), 64'h1);
    chk("lit_sys_pc", 64'(new_pc), 64'h20);
    chk("lit_sys_stall", 64'(stall), 64'h0);
    next_cyc(); exc = 32'h0;
    @(negedge clk);
    chk("lit_sys_after_flush", 64'(flush), 64'h0);
    chk("lit_sys_flush_count", 64'(flush_count), 64'h1);

    // ERET held off by a busy data bus.
    next_cyc(); epc = 32'h1234; exc = 32'he; req_mem = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("lit_hold_flush", 64'(flush), 64'h0);
      chk("lit_hold_stall", 64'(stall), 64'h1f);
      next_cyc();
    end
    req_mem = 1'b0;
    @(negedge clk);
    chk("lit_eret_flush", 64'(flush), 64'h1);
    chk("lit_eret_pc", 64'(new_pc), 64'h1234);
    next_cyc(); exc = 32'h0;

    // Flush with a fetch in flight.
    exc = 32'h8; req_if = 1'b1;
    @(negedge clk); chk("lit_drain_enter", 64'(if_discard), 64'h0);
    next_cyc(); exc = 32'h0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); chk("lit_drain_busy", 64'(if_discard), 64'h1);
      next_cyc();
    end
    req_if = 1'b0;
    @(negedge clk); chk("lit_drain_return", 64'(if_discard), 64'h1);
    next_cyc();
    @(negedge clk); chk("lit_drain_done", 64'(if_discard), 64'h0);

    // Flush again while draining, then reset mid-drain.
    next_cyc(); exc = 32'h8; req_if = 1'b1;
    next_cyc();
    @(negedge clk);
    chk("lit_drain_reflush", 64'(flush), 64'h1);
    chk("lit_drain_reflush_disc", 64'(if_discard), 64'h1);
    next_cyc(); exc = 32'h0;
    @(negedge clk); chk("lit_drain_still", 64'(if_discard), 64'h1);
    #2 rst = 1'b0;
    #1;
    chk("lit_rst_mid_discard", 64'(if_discard), 64'h0);
    chk("lit_rst_mid_stall", 64'(stall), 64'h0);
    chk("lit_rst_mid_cnt", 64'(flush_count), 64'h0);
    next_cyc(); rst = 1'b1; req_if = 1'b0;
    @(negedge clk); chk("lit_rst_released", 64'(if_discard), 64'h0);

    // Saturation and clear.
    next_cyc(); req_id = 1'b1;
    repeat (3) @(posedge clk);
    #1 req_id = 1'b0; exc = 32'h8;
    repeat (65537) @(posedge clk);
    #1 exc = 32'h0;
    @(negedge clk);
    chk("lit_flush_sat", 64'(flush_count), 64'hffff);
    chk("lit_stall_cnt_3", 64'(stall_cycles), 64'd3);
    next_cyc(); cnt_clr = 1'b1; req_ex = 1'b1; exc = 32'h8;
    next_cyc(); cnt_clr = 1'b0; req_ex = 1'b0; exc = 32'h0;
    @(negedge clk);
    chk("lit_clr_flush", 64'(flush_count), 64'h0);
    chk("lit_clr_stall", 64'(stall_cycles), 64'h0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
